// File: rtl/assoc_data_cache_if.sv
// CPU-side and memory-side bus of the 2-way data cache.
// slave: the cache itself; master: the CPU/memory environment driving it.
interface assoc_data_cache_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int OFF_W  = 2,
    parameter int CNT_W  = 16
);
    localparam int MADDR_W = ADDR_W - OFF_W;
    localparam int BLK_W   = DATA_W << OFF_W;

    logic               read;
    logic               write;
    logic [ADDR_W-1:0]  address;
    logic [DATA_W-1:0]  writedata;
    logic [DATA_W-1:0]  readdata;
    logic               busywait;
    logic               mem_read;
    logic               mem_write;
    logic [MADDR_W-1:0] mem_address;
    logic [BLK_W-1:0]   mem_writedata;
    logic [BLK_W-1:0]   mem_readdata;
    logic               mem_busywait;
    logic [CNT_W-1:0]   hit_count;
    logic [CNT_W-1:0]   miss_count;

    modport slave (
        input  read, write, address, writedata, mem_readdata, mem_busywait,
        output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata,
               hit_count, miss_count
    );

    modport master (
        output read, write, address, writedata, mem_readdata, mem_busywait,
        input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata,
               hit_count, miss_count
    );
endinterface

// File: rtl/assoc_data_cache.sv
// 2-way set-associative write-back/write-allocate data cache with per-set LRU
// and saturating hit/miss counters. States: IDLE, WRITEBACK, ALLOCATE, UPDATE.
module assoc_data_cache #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int OFF_W  = 2,
    parameter int IDX_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    assoc_data_cache_if.slave   bus
);
    localparam int SETS  = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int BLK_W = DATA_W << OFF_W;
    localparam int MA_W  = ADDR_W - OFF_W;

    typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE, S_UPDATE} state_t;
    state_t r_state, w_state_nxt;

    logic [SETS-1:0]  r_valid [2];
    logic [SETS-1:0]  r_dirty [2];
    logic [SETS-1:0]  r_lru;
    logic [TAG_W-1:0] r_tag  [2][SETS];
    logic [BLK_W-1:0] r_data [2][SETS];

    logic             r_victim;
    logic [TAG_W-1:0] r_miss_tag;
    logic [IDX_W-1:0] r_miss_idx;
    logic [BLK_W-1:0] r_fill;
    logic             r_retry;
    logic [CNT_W-1:0] r_hit_cnt, r_miss_cnt;
    logic             r_mem_read, r_mem_write;
    logic [MA_W-1:0]  r_mem_addr;
    logic [BLK_W-1:0] r_mem_wdata;

    logic [TAG_W-1:0] w_tag, w_sel_tag;
    logic [IDX_W-1:0] w_idx, w_sel_idx;
    logic [OFF_W-1:0] w_off;
    logic             w_req, w_match0, w_match1, w_hit, w_hit_way, w_done, w_miss_start;
    logic             w_victim, w_sel_victim;
    logic [BLK_W-1:0] w_hit_blk;
    logic             w_mem_read_nxt, w_mem_write_nxt;
    logic [MA_W-1:0]  w_mem_addr_nxt;
    logic [BLK_W-1:0] w_mem_wdata_nxt;

    assign w_tag        = bus.address[ADDR_W-1 -: TAG_W];
    assign w_idx        = bus.address[OFF_W +: IDX_W];
    assign w_off        = bus.address[OFF_W-1:0];
    assign w_req        = bus.read | bus.write;
    assign w_match0     = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
    assign w_match1     = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
    assign w_hit        = w_req & (w_match0 | w_match1);
    assign w_hit_way    = w_match1;
    assign w_done       = w_hit & (r_state == S_IDLE);
    assign w_miss_start = w_req & ~w_hit & (r_state == S_IDLE);
    assign w_victim     = !r_valid[0][w_idx] ? 1'b0 :
                          !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];
    assign w_hit_blk    = r_data[w_hit_way][w_idx];

    // While leaving IDLE the miss context is not yet latched, so use the live request.
    assign w_sel_victim = (r_state == S_IDLE) ? w_victim : r_victim;
    assign w_sel_idx    = (r_state == S_IDLE) ? w_idx    : r_miss_idx;
    assign w_sel_tag    = (r_state == S_IDLE) ? w_tag    : r_miss_tag;

    assign bus.readdata      = (w_hit && !i_rst) ? w_hit_blk[int'(w_off)*DATA_W +: DATA_W] : '0;
    assign bus.busywait      = ~i_rst & w_req & ~w_done;
    assign bus.mem_read      = r_mem_read;
    assign bus.mem_write     = r_mem_write;
    assign bus.mem_address   = r_mem_addr;
    assign bus.mem_writedata = r_mem_wdata;
    assign bus.hit_count     = r_hit_cnt;
    assign bus.miss_count    = r_miss_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:
                if (w_miss_start)
                    w_state_nxt = (r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx]) ?
                                  S_WRITEBACK : S_ALLOCATE;
            S_WRITEBACK: if (!bus.mem_busywait) w_state_nxt = S_ALLOCATE;
            S_ALLOCATE:  if (!bus.mem_busywait) w_state_nxt = S_UPDATE;
            S_UPDATE:    w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_mem_read_nxt  = 1'b0;
        w_mem_write_nxt = 1'b0;
        w_mem_addr_nxt  = '0;
        w_mem_wdata_nxt = '0;
        case (w_state_nxt)
            S_WRITEBACK: begin
                w_mem_write_nxt = 1'b1;
                w_mem_addr_nxt  = {r_tag[w_sel_victim][w_sel_idx], w_sel_idx};
                w_mem_wdata_nxt = r_data[w_sel_victim][w_sel_idx];
            end
            S_ALLOCATE: begin
                w_mem_read_nxt = 1'b1;
                w_mem_addr_nxt = {w_sel_tag, w_sel_idx};
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid[0]  <= '0;
            r_valid[1]  <= '0;
            r_dirty[0]  <= '0;
            r_dirty[1]  <= '0;
            r_lru       <= '0;
            r_victim    <= 1'b0;
            r_miss_tag  <= '0;
            r_miss_idx  <= '0;
            r_retry     <= 1'b0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_read  <= w_mem_read_nxt;
            r_mem_write <= w_mem_write_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            if (w_miss_start) begin
                r_victim   <= w_victim;
                r_miss_tag <= w_tag;
                r_miss_idx <= w_idx;
                if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
            end
            if (r_state == S_UPDATE) begin
                r_valid[r_victim][r_miss_idx] <= 1'b1;
                r_dirty[r_victim][r_miss_idx] <= 1'b0;
                r_retry                       <= 1'b1;
            end
            // The completion of a refilled request is not a genuine hit.
            if (w_done) begin
                r_lru[w_idx] <= ~w_hit_way;
                if (bus.write) r_dirty[w_hit_way][w_idx] <= 1'b1;
                if (r_retry)                 r_retry   <= 1'b0;
                else if (r_hit_cnt != '1)    r_hit_cnt <= r_hit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (r_state == S_ALLOCATE && !bus.mem_busywait) r_fill <= bus.mem_readdata;
        if (r_state == S_UPDATE) begin
            r_data[r_victim][r_miss_idx] <= r_fill;
            r_tag[r_victim][r_miss_idx]  <= r_miss_tag;
        end
        if (w_done && bus.write && !i_rst)
            r_data[w_hit_way][w_idx][int'(w_off)*DATA_W +: DATA_W] <= bus.writedata;
    end
endmodule

// File: tb/tb_assoc_data_cache.sv
// Directed bench for assoc_data_cache: expected CPU responses and memory
// transactions are queued by the stimulus and checked by a negedge monitor.
module tb_assoc_data_cache;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int OFF_W  = 2;
    localparam int CNT_W  = 4;
    localparam int LAT    = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    assoc_data_cache_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OFF_W(OFF_W), .CNT_W(CNT_W)) bus();

    assoc_data_cache #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OFF_W(OFF_W), .IDX_W(2), .CNT_W(CNT_W))
        u_dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic chk; logic [7:0] data; } cpu_exp_t;
    typedef struct packed { logic is_wr; logic [5:0] addr; logic [31:0] wdata; } mem_exp_t;
    cpu_exp_t cpu_q[$];
    mem_exp_t mem_q[$];

    // Block memory: block b holds bytes 4b+3..4b, with a fixed access latency.
    logic [31:0] mem [64];
    int          mem_cnt;
    logic        mem_loaded = 1'b0;

    assign bus.mem_busywait = (bus.mem_read | bus.mem_write) && (mem_cnt != LAT);
    assign bus.mem_readdata = mem[bus.mem_address];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_cnt <= 0;
            if (!mem_loaded) begin
                for (int b = 0; b < 64; b++)
                    mem[b] <= {8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)};
                mem_loaded <= 1'b1;
            end
        end else if (bus.mem_read | bus.mem_write) begin
            if (mem_cnt == LAT) begin
                mem_cnt <= 0;
                if (bus.mem_write) mem[bus.mem_address] <= bus.mem_writedata;
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end else begin
            mem_cnt <= 0;
        end
    end

    logic [1:0] prev_mem = 2'b00;
    always @(negedge clk) begin
        logic [1:0] cur;
        cpu_exp_t   ce;
        mem_exp_t   me;
        if (rst) begin
            prev_mem = 2'b00;
        end else begin
            if ((bus.read | bus.write) && !bus.busywait) begin
                if (cpu_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cpu_unexpected_completion addr=%0h", bus.address);
                end else begin
                    ce = cpu_q.pop_front();
                    if (ce.chk) begin
                        checks++;
                        if (bus.readdata !== ce.data) begin
                            errors++;
                            $display("FAIL readdata addr=%0h got=%0h want=%0h", bus.address, bus.readdata, ce.data);
                        end
                    end
                end
            end
            cur = {bus.mem_read, bus.mem_write};
            if (cur != prev_mem && cur != 2'b00) begin
                checks++;
                if (cur == 2'b11) begin
                    errors++;
                    $display("FAIL mem_rd_wr_both got=11 want=one-hot");
                end else if (mem_q.size() == 0) begin
                    errors++;
                    $display("FAIL mem_unexpected got rd=%0b wr=%0b addr=%0h want=none", cur[1], cur[0], bus.mem_address);
                end else begin
                    me = mem_q.pop_front();
                    if (me.is_wr != cur[0] || me.addr != bus.mem_address ||
                        (me.is_wr && bus.mem_writedata !== me.wdata)) begin
                        errors++;
                        $display("FAIL mem_txn got wr=%0b addr=%0h wdata=%0h want wr=%0b addr=%0h wdata=%0h",
                                 cur[0], bus.mem_address, bus.mem_writedata, me.is_wr, me.addr, me.wdata);
                    end
                end
            end
            prev_mem = cur;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic exp_mem(input logic wr, input logic [5:0] addr, input logic [31:0] wdata);
        mem_q.push_back({wr, addr, wdata});
    endtask

    task automatic cpu_op(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic chk_data, input logic [7:0] exp, input logic exp_hit);
        int n;
        cpu_q.push_back({chk_data, exp});
        @(posedge clk); #1;
        bus.read = ~wr; bus.write = wr; bus.address = addr; bus.writedata = wdata;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (!bus.busywait) break;
            n++;
        end
        if (n == 100) begin
            checks++; errors++;
            $display("FAIL cpu_timeout addr=%0h got=busy want=done", addr);
            void'(cpu_q.pop_back());
        end else begin
            chk($sformatf("hit_latency_%0h", addr), 32'(n == 0), 32'(exp_hit));
        end
        @(posedge clk); #1;
        bus.read = 1'b0; bus.write = 1'b0;
    endtask

    logic [7:0] blk1 [4];

    initial begin
        int n;
        bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.writedata = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busywait", 32'(bus.busywait), 0);
        chk("rst_readdata", 32'(bus.readdata), 0);
        chk("rst_mem_read", 32'(bus.mem_read), 0);
        chk("rst_mem_write", 32'(bus.mem_write), 0);
        chk("rst_hit_count", 32'(bus.hit_count), 0);
        chk("rst_miss_count", 32'(bus.miss_count), 0);
        rst = 1'b0;

        // Test 1: cold miss then same-block hit
        exp_mem(1'b0, 6'h00, '0);
        cpu_op(1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0);
        chk("t1_miss_count", 32'(bus.miss_count), 1);
        chk("t1_hit_count_retry", 32'(bus.hit_count), 0);
        cpu_op(1'b0, 8'h01, 8'h00, 1'b1, 8'h01, 1'b1);
        chk("t1_hit_count", 32'(bus.hit_count), 1);

        // Test 2: second tag in set 0 fills way1
        cpu_op(1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1);
        exp_mem(1'b0, 6'h04, '0);
        cpu_op(1'b0, 8'h10, 8'h00, 1'b1, 8'h10, 1'b0);
        cpu_op(1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1);
        cpu_op(1'b0, 8'h10, 8'h00, 1'b1, 8'h10, 1'b1);
        chk("t2_miss_count", 32'(bus.miss_count), 2);
        chk("t2_hit_count", 32'(bus.hit_count), 4);

        // Test 3: LRU evicts clean way1
        cpu_op(1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1);
        exp_mem(1'b0, 6'h08, '0);
        cpu_op(1'b0, 8'h20, 8'h00, 1'b1, 8'h20, 1'b0);
        cpu_op(1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1);
        exp_mem(1'b0, 6'h04, '0);
        cpu_op(1'b0, 8'h10, 8'h00, 1'b1, 8'h10, 1'b0);

        // Test 4: dirty victim written back before refill
        exp_mem(1'b0, 6'h01, '0);
        cpu_op(1'b1, 8'h05, 8'hAA, 1'b0, 8'h00, 1'b0);
        exp_mem(1'b0, 6'h05, '0);
        cpu_op(1'b0, 8'h15, 8'h00, 1'b1, 8'h15, 1'b0);
        cpu_op(1'b0, 8'h15, 8'h00, 1'b1, 8'h15, 1'b1);
        exp_mem(1'b1, 6'h01, 32'h0706AA04);
        exp_mem(1'b0, 6'h09, '0);
        cpu_op(1'b0, 8'h25, 8'h00, 1'b1, 8'h25, 1'b0);
        exp_mem(1'b0, 6'h01, '0);
        cpu_op(1'b0, 8'h05, 8'h00, 1'b1, 8'hAA, 1'b0);
        chk("t4_miss_count", 32'(bus.miss_count), 8);
        chk("t4_hit_count", 32'(bus.hit_count), 7);

        // Test 5: reset during a writeback
        cpu_op(1'b1, 8'h25, 8'h77, 1'b0, 8'h00, 1'b1);
        cpu_op(1'b1, 8'h05, 8'h66, 1'b0, 8'h00, 1'b1);
        chk("t5_hit_count_pre", 32'(bus.hit_count), 9);
        exp_mem(1'b1, 6'h09, 32'h27267724);
        @(posedge clk); #1;
        bus.read = 1'b1; bus.address = 8'h35;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (bus.mem_write) break;
            n++;
        end
        if (n == 20) begin
            checks++; errors++;
            $display("FAIL t5_wait_mem_write got=0 want=1");
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_mem_write", 32'(bus.mem_write), 0);
        chk("t5_mem_read", 32'(bus.mem_read), 0);
        chk("t5_busywait", 32'(bus.busywait), 0);
        chk("t5_hit_count", 32'(bus.hit_count), 0);
        chk("t5_miss_count", 32'(bus.miss_count), 0);
        chk("t5_mem_address", 32'(bus.mem_address), 0);
        bus.read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_mem(1'b0, 6'h01, '0);
        cpu_op(1'b0, 8'h05, 8'h00, 1'b1, 8'hAA, 1'b0);
        chk("t5_miss_after", 32'(bus.miss_count), 1);

        // Test 6: hit counter saturates
        blk1[0] = 8'h04; blk1[1] = 8'hAA; blk1[2] = 8'h06; blk1[3] = 8'h07;
        for (int i = 0; i < 20; i++) begin
            cpu_op(1'b0, 8'h04 + 8'(i % 4), 8'h00, 1'b1, blk1[i % 4], 1'b1);
            if (i == 14) chk("t6_hit_count_15", 32'(bus.hit_count), 15);
        end
        chk("t6_hit_count_sat", 32'(bus.hit_count), 32'hF);
        chk("t6_miss_count", 32'(bus.miss_count), 1);

        repeat (2) @(negedge clk);
        chk("cpu_queue_drained", 32'(cpu_q.size()), 0);
        chk("mem_queue_drained", 32'(mem_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
